// File: rtl/xadc_axis_burst_writer.sv
// rtl/xadc_axis_burst_writer.sv - XADC sample packer, word FIFO and DDR ring burst writer
// Matched 16-bit samples are packed four per 64-bit word and written to a ring as fixed-length bursts.
module xadc_axis_burst_writer #(
    parameter int FIFO_AW   = 4,
    parameter int BURST_LEN = 8
) (
    input  logic        clk_adc_125mhz,
    input  logic        adc_rst_i,
    input  logic        cfg_en_i,
    input  logic [4:0]  cfg_tid_i,
    input  logic [31:0] cfg_base_i,
    input  logic [31:0] cfg_size_i,
    input  logic [15:0] s_tdata_i,
    input  logic [4:0]  s_tid_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    output logic [31:0] axi_waddr_o,
    output logic [63:0] axi_wdata_o,
    output logic [7:0]  axi_wsel_o,
    output logic        axi_wvalid_o,
    output logic [3:0]  axi_wlen_o,
    output logic        axi_wfixed_o,
    input  logic        axi_werr_i,
    input  logic        axi_wrdy_i,
    output logic        stat_busy_o,
    output logic [31:0] stat_wr_ofs_o,
    output logic [15:0] stat_wraps_o,
    output logic        stat_err_o
);
    localparam int               DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] BURST_CNT   = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] CNT_ONE     = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [3:0]       LAST_BEAT   = 4'(BURST_LEN - 1);
    localparam logic [31:0]      BURST_BYTES = 32'(BURST_LEN * 8);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BURST} state_t;

    state_t             state_q;
    logic [31:0]        base_q;
    logic [31:0]        size_q;
    logic [31:0]        ofs_q;
    logic [31:0]        waddr_q;
    logic [4:0]         tid_q;
    logic [15:0]        wraps_q;
    logic               err_q;
    logic               wvalid_q;
    logic [3:0]         beat_q;
    logic [1:0]         lane_q;
    logic [47:0]        word_q;
    logic [63:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;

    logic               fifo_full;
    logic               take;
    logic               push;
    logic               pop;
    logic               last_beat;
    logic               flush;
    logic [31:0]        ofs_inc;
    logic [31:0]        ofs_d;
    logic [15:0]        wraps_d;
    logic [FIFO_AW:0]   cnt_d;

    assign fifo_full  = (cnt_q == DEPTH_CNT);
    assign s_tready_o = ((state_q == ST_RUN) || (state_q == ST_BURST)) && !fifo_full;
    assign take       = s_tvalid_i && s_tready_o && (s_tid_i == tid_q);
    assign push       = take && (lane_q == 2'd3);
    assign pop        = wvalid_q && axi_wrdy_i;
    assign last_beat  = pop && (beat_q == LAST_BEAT);
    // Leaving RUN for IDLE throws away both the partial word and the queued words.
    assign flush      = (state_q == ST_RUN) && !cfg_en_i;
    assign ofs_inc    = ofs_q + BURST_BYTES;

    always_comb begin
        ofs_d   = ofs_inc;
        wraps_d = wraps_q;
        if (ofs_inc == size_q) begin
            ofs_d = '0;
            if (wraps_q != 16'hFFFF) begin
                wraps_d = wraps_q + 16'd1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_adc_125mhz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_tdata_i, word_q};
        end
    end

    always_ff @(posedge clk_adc_125mhz) begin
        if (adc_rst_i) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            size_q   <= '0;
            ofs_q    <= '0;
            waddr_q  <= '0;
            tid_q    <= '0;
            wraps_q  <= '0;
            err_q    <= 1'b0;
            wvalid_q <= 1'b0;
            beat_q   <= '0;
            lane_q   <= '0;
            word_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (flush) begin
                lane_q   <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (take) begin
                    lane_q <= lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    word_q[15:0]  <= s_tdata_i;
                        2'd1:    word_q[31:16] <= s_tdata_i;
                        2'd2:    word_q[47:32] <= s_tdata_i;
                        default: ;
                    endcase
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                cnt_q <= cnt_d;
            end

            if ((state_q != ST_IDLE) && axi_werr_i) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cfg_en_i) begin
                        base_q  <= cfg_base_i;
                        size_q  <= cfg_size_i;
                        tid_q   <= cfg_tid_i;
                        ofs_q   <= '0;
                        wraps_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!cfg_en_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q >= BURST_CNT) begin
                        beat_q   <= '0;
                        wvalid_q <= 1'b1;
                        waddr_q  <= base_q + ofs_q;
                        state_q  <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (pop) begin
                        beat_q <= beat_q + 4'd1;
                        if (last_beat) begin
                            ofs_q    <= ofs_d;
                            wraps_q  <= wraps_d;
                            wvalid_q <= 1'b0;
                            state_q  <= ST_RUN;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign axi_waddr_o   = waddr_q;
    assign axi_wdata_o   = wvalid_q ? mem_q[rd_ptr_q] : 64'd0;
    assign axi_wsel_o    = 8'hFF;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wlen_o    = LAST_BEAT;
    assign axi_wfixed_o  = 1'b0;
    assign stat_busy_o   = (state_q != ST_IDLE);
    assign stat_wr_ofs_o = ofs_q;
    assign stat_wraps_o  = wraps_q;
    assign stat_err_o    = err_q;

endmodule

// File: tb/tb_xadc_axis_burst_writer.sv
// tb/tb_xadc_axis_burst_writer.sv - randomized bench with a sample-queue reference model
module tb_xadc_axis_burst_writer;
    localparam int BL = 8;
    localparam int BB = BL * 8;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic [4:0]  cfg_tid;
    logic [31:0] cfg_base;
    logic [31:0] cfg_size;
    logic [15:0] s_tdata;
    logic [4:0]  s_tid;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wsel;
    logic        wvalid;
    logic [3:0]  wlen;
    logic        wfixed;
    logic        werr;
    logic        wrdy;
    logic        busy;
    logic [31:0] wr_ofs;
    logic [15:0] wraps;
    logic        err;

    xadc_axis_burst_writer #(.FIFO_AW(4), .BURST_LEN(BL)) dut (
        .clk_adc_125mhz(clk), .adc_rst_i(rst), .cfg_en_i(cfg_en), .cfg_tid_i(cfg_tid),
        .cfg_base_i(cfg_base), .cfg_size_i(cfg_size), .s_tdata_i(s_tdata), .s_tid_i(s_tid),
        .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .axi_waddr_o(waddr), .axi_wdata_o(wdata),
        .axi_wsel_o(wsel), .axi_wvalid_o(wvalid), .axi_wlen_o(wlen), .axi_wfixed_o(wfixed),
        .axi_werr_i(werr), .axi_wrdy_i(wrdy), .stat_busy_o(busy), .stat_wr_ofs_o(wr_ofs),
        .stat_wraps_o(wraps), .stat_err_o(err)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: matched samples in transfer order, ring geometry, burst count.
    logic [15:0] exp_q[$];
    logic [31:0] obs_addr[$];
    logic [63:0] obs_beat[BL];
    logic [31:0] m_base;
    logic [31:0] m_size;
    logic [4:0]  m_tid;
    int          bursts;
    int          beat_idx;
    int          n_xfer;
    int          wr_mode;

    always @(negedge clk) begin
        logic [63:0] exp_word;
        logic [63:0] exp_addr;
        if (!rst) begin
            if (wvalid && wrdy) begin
                exp_addr = 64'(m_base) + ((64'(bursts) * BB) % 64'(m_size));
                chk("waddr", 64'(waddr), exp_addr);
                if (beat_idx == 0) begin
                    obs_addr.push_back(waddr);
                    chk("wsel_wlen", {wsel, wlen, 3'b0, wfixed}, {8'hFF, 4'(BL - 1), 4'h0});
                end
                if (exp_q.size() < 4) begin
                    chk("beat_underflow", 64'(exp_q.size()), 64'd4);
                end else begin
                    for (int k = 0; k < 4; k++) exp_word[16*k +: 16] = exp_q.pop_front();
                    chk("wdata", wdata, exp_word);
                end
                obs_beat[beat_idx] = wdata;
                beat_idx++;
                if (beat_idx == BL) begin
                    beat_idx = 0;
                    bursts++;
                end
            end
            if (s_tvalid && s_tready && s_tid == m_tid) begin
                exp_q.push_back(s_tdata);
                n_xfer++;
            end
        end
    end

    initial begin
        wrdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                0:       wrdy = 1'b1;
                1:       wrdy = ($urandom_range(0, 2) != 0);
                default: wrdy = 1'b0;
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] t);
        int to;
        s_tdata  = d;
        s_tid    = t;
        s_tvalid = 1'b1;
        to = 0;
        while (1) begin
            @(negedge clk);
            if (s_tready) break;
            to++;
            if (to > 3000) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    // mode 0: data i+1; 1: random data with gaps; 2: data i+1 with a foreign 0xAAAA before each;
    // 3: random data, random foreign samples, random gaps
    task automatic stream(input int n, input int mode);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = (mode == 0 || mode == 2) ? 16'(i + 1) : 16'($urandom);
            if (mode == 2) send(16'hAAAA, 5'h10);
            if (mode == 3 && $urandom_range(0, 3) == 0) send(16'($urandom), m_tid ^ 5'h01);
            send(d, m_tid);
            if (mode == 1 || mode == 3) cyc($urandom_range(0, 2));
        end
    endtask

    task automatic enable(input logic [31:0] b, input logic [31:0] s, input logic [4:0] t);
        cfg_base = b;
        cfg_size = s;
        cfg_tid  = t;
        m_base   = b;
        m_size   = s;
        m_tid    = t;
        bursts   = 0;
        beat_idx = 0;
        exp_q.delete();
        obs_addr.delete();
        cfg_en = 1'b1;
        cyc(2);
    endtask

    task automatic disable_wait();
        int to;
        cfg_en = 1'b0;
        to = 0;
        @(negedge clk);
        while (busy && to < 2000) begin
            @(negedge clk);
            to++;
        end
        chk("idle_reached", 64'(busy), 64'd0);
        cyc(1);
        exp_q.delete();
    endtask

    task automatic drain();
        int to;
        to = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || beat_idx != 0 || wvalid) && to < 5000) begin
            @(negedge clk);
            to++;
        end
        chk("drain", 64'(exp_q.size() + beat_idx), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_stats();
        longint tot;
        longint w;
        tot = longint'(bursts) * BB;
        w   = tot / longint'(m_size);
        if (w > 65535) w = 65535;
        chk("wr_ofs", 64'(wr_ofs), 64'(tot % longint'(m_size)));
        chk("wraps", 64'(wraps), 64'(w));
    endtask

    initial begin
        int n0;
        int to;
        int k;
        logic [4:0] t;
        rst = 1'b1; cfg_en = 1'b0; cfg_tid = '0; cfg_base = '0; cfg_size = '0;
        s_tdata = '0; s_tid = '0; s_tvalid = 1'b0; werr = 1'b0; wr_mode = 0;
        m_base = '0; m_size = 32'd64; m_tid = '0; bursts = 0; beat_idx = 0; n_xfer = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_busy", {s_tready, busy, wvalid, err}, 4'b0000);
        chk("rst_waddr_wdata", {32'd0, waddr} | wdata, 64'd0);
        chk("rst_consts", {wsel, wlen, 3'b0, wfixed}, {8'hFF, 4'd7, 4'h0});
        chk("rst_stats", {wr_ofs, wraps}, 48'd0);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);

        // Packing
        wr_mode = 0;
        enable(32'h1000_0000, 32'h200, 5'h03);
        stream(32, 0);
        drain();
        chk("pack_beat0", obs_beat[0], 64'h0004_0003_0002_0001);
        chk("pack_beat7", obs_beat[7], 64'h0020_001F_001E_001D);
        chk("pack_addr", 64'(obs_addr[0]), 64'h1000_0000);
        chk("pack_ofs", 64'(wr_ofs), 64'h40);
        chk_stats();
        disable_wait();

        // Filter: foreign-channel samples never enter the packed words
        enable(32'h1000_0000, 32'h200, 5'h03);
        stream(32, 2);
        drain();
        chk("filt_beat0", obs_beat[0], 64'h0004_0003_0002_0001);
        chk("filt_beat7", obs_beat[7], 64'h0020_001F_001E_001D);
        chk("filt_bursts", 64'(bursts), 64'd1);
        disable_wait();

        // Ring wrap
        enable(32'h1000_0000, 32'h80, 5'h03);
        stream(96, 1);
        drain();
        chk("wrap_nbursts", 64'(obs_addr.size()), 64'd3);
        if (obs_addr.size() == 3) begin
            chk("wrap_a0", 64'(obs_addr[0]), 64'h1000_0000);
            chk("wrap_a1", 64'(obs_addr[1]), 64'h1000_0040);
            chk("wrap_a2", 64'(obs_addr[2]), 64'h1000_0000);
        end
        chk("wrap_count", 64'(wraps), 64'd1);
        chk("wrap_ofs", 64'(wr_ofs), 64'h40);
        disable_wait();

        // Backpressure: FIFO fills, tready drops, nothing lost after release
        wr_mode = 2;
        enable(32'h2000_0000, 32'h400, 5'h07);
        n0 = n_xfer;
        k = 0;
        fork
            begin
                stream(80, 1);
                stream(16, 1);
                k = 1;
            end
        join_none
        repeat (150) @(negedge clk);
        chk("bp_tready", 64'(s_tready), 64'd0);
        chk("bp_accepted", 64'(n_xfer - n0), 64'd64);
        wr_mode = 1;
        to = 0;
        while (k == 0 && to < 20000) begin
            @(posedge clk);
            to++;
        end
        chk("bp_stream_done", 64'(k), 64'd1);
        #1;
        drain();
        chk("bp_bursts", 64'(bursts), 64'd3);
        chk_stats();
        disable_wait();

        // Error pulse and disable mid-burst
        wr_mode = 2;
        enable(32'h3000_0000, 32'h200, 5'h05);
        stream(40, 1);
        wr_mode = 1;
        to = 0;
        @(negedge clk);
        while (beat_idx < 2 && to < 2000) begin
            @(negedge clk);
            to++;
        end
        chk("err_burst_started", 64'(beat_idx >= 2), 64'd1);
        @(posedge clk);
        #1;
        werr = 1'b1;
        cyc(1);
        werr = 1'b0;
        disable_wait();
        chk("err_sticky", 64'(err), 64'd1);
        chk("dis_burst_done", 64'(beat_idx), 64'd0);
        chk("dis_bursts", 64'(bursts), 64'd1);
        chk("dis_idle", {s_tready, busy, wvalid}, 3'b000);

        // Randomized rings
        for (int it = 0; it < 4; it++) begin
            t = 5'($urandom);
            k = $urandom_range(1, 6);
            enable($urandom & 32'hFFFF_FFC0, 32'($urandom_range(1, 4) * BB), t);
            chk("rand_err_cleared", 64'(err), 64'd0);
            stream(k * 32, 3);
            drain();
            chk("rand_bursts", 64'(bursts), 64'(k));
            chk_stats();
            disable_wait();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
